// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation and FSM state encodings plus small op-decode helpers.
package mdu_seq_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_S_IDLE = 3'd0,
    MDU_S_MUL  = 3'd1,
    MDU_S_DIV  = 3'd2,
    MDU_S_FIX  = 3'd3,
    MDU_S_DONE = 3'd4
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes (combinational).
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  // Extra top bit on the trial subtraction acts as the borrow/sign flag.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {2'b00, divisor};
    rem_next = rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_next    = trial[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer for EX: 2-cycle multiply, restoring divide with
// sign fixup, and HI/LO results held until the pipeline advances or flushes.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32,
  parameter int unsigned WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ex_adv,
  input  logic             op_valid,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             mdu_stall_req,
  output logic             mdu_res_valid,
  output logic [WIDTH-1:0] mdu_hi_res,
  output logic [WIDTH-1:0] mdu_lo_res
);

  localparam int unsigned CNT_W  = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  mdu_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] opa, opa_d;    // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] opb, opb_d;    // divisor / multiplier magnitude
  logic [WIDTH-1:0] rem, rem_d;
  logic             sign_a, sign_a_d;
  logic             sign_b, sign_b_d;
  logic             res_valid_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic [WIDTH-1:0] rem_step, quo_step;
  logic [PROD_W-1:0] prod;
  mdu_op_e           op;
  logic              sgn;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .quo      (opa),
    .divisor  (opb),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  assign mdu_stall_req = op_valid & ~flush & (state != MDU_S_DONE);

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    opa_d       = opa;
    opb_d       = opb;
    rem_d       = rem;
    sign_a_d    = sign_a;
    sign_b_d    = sign_b;
    res_valid_d = mdu_res_valid;
    hi_d        = mdu_hi_res;
    lo_d        = mdu_lo_res;
    prod        = '0;
    op          = mdu_op_e'(op_sel);
    sgn         = op_is_signed(op);

    case (state)
      MDU_S_IDLE: begin
        if (op_valid) begin
          sign_a_d = sgn & src_a[WIDTH-1];
          sign_b_d = sgn & src_b[WIDTH-1];
          opa_d    = (sgn & src_a[WIDTH-1]) ? -src_a : src_a;
          opb_d    = (sgn & src_b[WIDTH-1]) ? -src_b : src_b;
          rem_d    = '0;
          if (op_is_div(op)) begin
            state_d = MDU_S_DIV;
            cnt_d   = CNT_W'(DIV_ITERS - 1);
          end else begin
            state_d = MDU_S_MUL;
          end
        end
      end
      MDU_S_MUL: begin
        prod = PROD_W'(opa) * PROD_W'(opb);
        if (sign_a ^ sign_b) prod = -prod;
        hi_d        = prod[PROD_W-1:WIDTH];
        lo_d        = prod[WIDTH-1:0];
        res_valid_d = 1'b1;
        state_d     = MDU_S_DONE;
      end
      MDU_S_DIV: begin
        rem_d = rem_step;
        opa_d = quo_step;
        if (cnt == '0) state_d = MDU_S_FIX;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      MDU_S_FIX: begin
        hi_d        = sign_a ? -rem : rem;
        lo_d        = (sign_a ^ sign_b) ? -opa : opa;
        res_valid_d = 1'b1;
        state_d     = MDU_S_DONE;
      end
      MDU_S_DONE: begin
        if (ex_adv) begin
          state_d     = MDU_S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = MDU_S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    // Flush wins over completion, ex_adv and starting a new operation.
    if (flush) begin
      state_d     = MDU_S_IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MDU_S_IDLE;
      cnt           <= '0;
      opa           <= '0;
      opb           <= '0;
      rem           <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      mdu_res_valid <= 1'b0;
      mdu_hi_res    <= '0;
      mdu_lo_res    <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      opa           <= opa_d;
      opb           <= opb_d;
      rem           <= rem_d;
      sign_a        <= sign_a_d;
      sign_b        <= sign_b_d;
      mdu_res_valid <= res_valid_d;
      mdu_hi_res    <= hi_d;
      mdu_lo_res    <= lo_d;
    end
  end

  // EX must keep the instruction presented while the operation is in flight.
  a_op_held: assert property (@(posedge clk) disable iff (rst)
    (state inside {MDU_S_MUL, MDU_S_DIV, MDU_S_FIX}) |-> (op_valid || flush));

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: driver pushes reference results, a negedge
// monitor compares HI/LO whenever the DUT presents a valid result.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_adv;
  logic        op_valid;
  logic [1:0]  op_sel;
  logic [31:0] src_a, src_b;
  logic        mdu_stall_req;
  logic        mdu_res_valid;
  logic [31:0] mdu_hi_res, mdu_lo_res;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mdu_seq #(.DIV_ITERS(32), .WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ex_adv        (ex_adv),
    .op_valid      (op_valid),
    .op_sel        (op_sel),
    .src_a         (src_a),
    .src_b         (src_b),
    .mdu_stall_req (mdu_stall_req),
    .mdu_res_valid (mdu_res_valid),
    .mdu_hi_res    (mdu_hi_res),
    .mdu_lo_res    (mdu_lo_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {hi, lo} from plain arithmetic on the operation semantics.
  function automatic logic [63:0] model(input logic [1:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      2'd0: begin p = sa * sb; return 64'(p); end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
        return {r, q};
      end
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid cycle must show the oldest outstanding result.
  always @(negedge clk) begin
    #1;
    if (!rst && mdu_res_valid) begin
      check("stall_in_done", 64'(mdu_stall_req), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h%h expected none", mdu_hi_res, mdu_lo_res);
      end else begin
        check("hi_lo", {mdu_hi_res, mdu_lo_res}, exp_q[0]);
        if (ex_adv) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int  n;
    bit  done;
    @(negedge clk);
    op_valid = 1'b1;
    op_sel   = sel;
    src_a    = a;
    src_b    = b;
    ex_adv   = 1'b0;
    exp_q.push_back(model(sel, a, b));
    n    = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (mdu_res_valid) done = 1;
      else begin
        if (mdu_stall_req) n++;
        @(negedge clk);
      end
    end
    check("completed", 64'(done), 64'd1);
    check("stall_cycles", 64'(n), sel[1] ? 64'd34 : 64'd2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("valid_held", 64'(mdu_res_valid), 64'd1);
    end
    @(negedge clk);
    ex_adv = 1'b1;
    @(negedge clk);
    ex_adv   = 1'b0;
    op_valid = 1'b0;
    #1;
    check("valid_drop", 64'(mdu_res_valid), 64'd0);
  endtask

  initial begin
    logic [1:0] s;
    rst = 1'b1; flush = 1'b0; ex_adv = 1'b0; op_valid = 1'b0;
    op_sel = 2'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 64'(mdu_res_valid), 64'd0);
    check("rst_hi_lo", {mdu_hi_res, mdu_lo_res}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_stall", 64'(mdu_stall_req), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd3, 32'd100, 32'd0, 1);
    run_op(2'd3, 32'd100, 32'd7, 4);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);

    // Flush mid-divide, then a fresh multiply must start from IDLE.
    @(negedge clk);
    op_valid = 1'b1; op_sel = 2'd3; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(mdu_stall_req), 64'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush_valid", 64'(mdu_res_valid), 64'd0);
    check("flush_idle_stall", 64'(mdu_stall_req), 64'd0);
    run_op(2'd1, 32'd6, 32'd7, 0);

    // Reset mid-divide clears results and returns to IDLE.
    @(negedge clk);
    op_valid = 1'b1; op_sel = 2'd2; src_a = 32'd12345; src_b = 32'd11;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    #1;
    check("midrst_valid", 64'(mdu_res_valid), 64'd0);
    check("midrst_hi_lo", {mdu_hi_res, mdu_lo_res}, 64'd0);
    run_op(2'd0, 32'd5, 32'hFFFF_FFFD, 0);

    for (int k = 0; k < 30; k++) begin
      s = 2'($urandom_range(0, 3));
      run_op(s, pick(), pick(), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
